// File: rtl/am_ctrl_pkg.sv
// Shared state encoding and default sizing for the AM-window BIP counter controller.
// Constants only; no logic and no latency.
package am_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SNAP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_N_LANES    = 20;
    localparam int DEF_NB_COUNTER = 32;
    localparam int DEF_WINDOW_AMS = 1024;

endpackage

// File: rtl/am_snapshot_drain.sv
// Shadow bank of lane counts: a one-cycle capture strobe loads it, then lanes drain in order.
// First word is valid the cycle after capture; each word holds until i_rd_ready accepts it.
module am_snapshot_drain
    import am_ctrl_pkg::*;
#(
    parameter int N_LANES    = DEF_N_LANES,
    parameter int NB_COUNTER = DEF_NB_COUNTER,
    parameter int NB_LANE    = $clog2(DEF_N_LANES)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_capture,
    input  logic [N_LANES*NB_COUNTER-1:0] i_count_bus,
    input  logic [N_LANES-1:0]            i_overflow,
    input  logic                          i_rd_ready,
    output logic                          o_rd_valid,
    output logic [NB_LANE-1:0]            o_rd_lane,
    output logic [NB_COUNTER-1:0]         o_rd_count,
    output logic                          o_rd_overflow,
    output logic                          o_rd_last,
    output logic                          o_drain_done
);

    logic [NB_COUNTER-1:0] r_shadow [N_LANES];
    logic [N_LANES-1:0]    r_shadow_ovf;
    logic [NB_LANE-1:0]    r_lane;
    logic                  r_valid;
    logic                  w_xfer;
    logic                  w_at_last;

    assign w_at_last = (r_lane == NB_LANE'(N_LANES - 1));
    assign w_xfer    = r_valid & i_rd_ready;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int l = 0; l < N_LANES; l++) begin
                r_shadow[l] <= '0;
            end
            r_shadow_ovf <= '0;
            r_lane       <= '0;
            r_valid      <= 1'b0;
        end else if (i_capture) begin
            for (int l = 0; l < N_LANES; l++) begin
                r_shadow[l] <= i_count_bus[l*NB_COUNTER +: NB_COUNTER];
            end
            r_shadow_ovf <= i_overflow;
            r_lane       <= '0;
            r_valid      <= 1'b1;
        end else if (w_xfer) begin
            r_lane  <= w_at_last ? '0 : r_lane + 1'b1;
            r_valid <= !w_at_last;
        end
    end

    // Read-port fields are forced to zero whenever no word is being offered.
    assign o_rd_valid    = r_valid;
    assign o_rd_lane     = r_valid ? r_lane : '0;
    assign o_rd_count    = r_valid ? r_shadow[r_lane] : '0;
    assign o_rd_overflow = r_valid & r_shadow_ovf[r_lane];
    assign o_rd_last     = r_valid & w_at_last;
    assign o_drain_done  = w_xfer & w_at_last;

endmodule

// File: rtl/am_bip_window_ctrl.sv
// Gates/clears per-lane BIP error counters on AM boundaries and snapshots them every WINDOW_AMS AMs.
// Snapshot one cycle after the closing AM, drain via valid/ready; AM_CTRL_BER_ALARM_EN adds lane alarms.
module am_bip_window_ctrl
    import am_ctrl_pkg::*;
#(
    parameter int N_LANES    = DEF_N_LANES,
    parameter int NB_COUNTER = DEF_NB_COUNTER,
    parameter int WINDOW_AMS = DEF_WINDOW_AMS,
    localparam int NB_LANE   = $clog2(N_LANES)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_am_valid,
    input  logic [N_LANES*NB_COUNTER-1:0] i_lane_err_count,
    input  logic [N_LANES-1:0]            i_lane_overflow,
    input  logic                          i_rd_ready,
    input  logic                          i_clear_flags,
    input  logic [NB_COUNTER-1:0]         i_ber_threshold,
    output logic                          o_count_enable,
    output logic [N_LANES-1:0]            o_reset_count,
    output logic                          o_rd_valid,
    output logic [NB_LANE-1:0]            o_rd_lane,
    output logic [NB_COUNTER-1:0]         o_rd_count,
    output logic                          o_rd_overflow,
    output logic                          o_rd_last,
    output logic                          o_window_done,
    output logic                          o_overrun,
    output logic [N_LANES-1:0]            o_ber_alarm
);

    localparam int NB_AM = $clog2(WINDOW_AMS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NB_AM-1:0] r_am_cnt;
    logic [NB_AM-1:0] w_am_cnt_nxt;
    logic             r_overrun;
    logic             w_overrun_set;
    logic             w_closing;
    logic             w_capture;
    logic             w_drain_done;

    assign w_closing = i_am_valid && (r_am_cnt == NB_AM'(WINDOW_AMS - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_am_cnt_nxt   = r_am_cnt;
        w_capture      = 1'b0;
        w_overrun_set  = 1'b0;
        o_count_enable = 1'b0;
        o_reset_count  = '0;
        o_window_done  = 1'b0;
        if (i_am_valid) begin
            w_am_cnt_nxt = w_closing ? '0 : r_am_cnt + 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                w_am_cnt_nxt = '0;
                if (i_enable) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                o_count_enable = 1'b1;
                // Disabling mid-window throws the partial window away.
                if (!i_enable) begin
                    o_reset_count = '1;
                    w_am_cnt_nxt  = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_closing) begin
                    w_state_nxt = ST_SNAP;
                end
            end
            ST_SNAP: begin
                o_count_enable = 1'b1;
                o_reset_count  = '1;
                o_window_done  = 1'b1;
                w_capture      = 1'b1;
                w_overrun_set  = w_closing;
                w_state_nxt    = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_count_enable = 1'b1;
                w_overrun_set  = w_closing;
                if (w_drain_done) begin
                    w_state_nxt = i_enable ? ST_COUNT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_am_cnt  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_am_cnt  <= w_am_cnt_nxt;
            r_overrun <= w_overrun_set ? 1'b1 : (i_clear_flags ? 1'b0 : r_overrun);
        end
    end

    assign o_overrun = r_overrun;

    am_snapshot_drain #(
        .N_LANES    (N_LANES),
        .NB_COUNTER (NB_COUNTER),
        .NB_LANE    (NB_LANE)
    ) u_snapshot_drain (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_capture     (w_capture),
        .i_count_bus   (i_lane_err_count),
        .i_overflow    (i_lane_overflow),
        .i_rd_ready    (i_rd_ready),
        .o_rd_valid    (o_rd_valid),
        .o_rd_lane     (o_rd_lane),
        .o_rd_count    (o_rd_count),
        .o_rd_overflow (o_rd_overflow),
        .o_rd_last     (o_rd_last),
        .o_drain_done  (w_drain_done)
    );

`ifdef AM_CTRL_BER_ALARM_EN
    logic [N_LANES-1:0] r_ber_alarm;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_ber_alarm <= '0;
        end else if (w_capture) begin
            for (int l = 0; l < N_LANES; l++) begin
                r_ber_alarm[l] <= (i_lane_err_count[l*NB_COUNTER +: NB_COUNTER] > i_ber_threshold)
                                  || i_lane_overflow[l];
            end
        end
    end

    assign o_ber_alarm = r_ber_alarm;
`else
    logic w_unused_ber_threshold;

    assign w_unused_ber_threshold = ^i_ber_threshold;
    assign o_ber_alarm            = '0;
`endif

endmodule
